// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer accepting up to FETCH_W
// lanes per cycle (gaps compacted) and presenting up to FETCH_W lanes to decode.
module fetch_queue #(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FETCH_W-1:0]            fetch_valid,
  input  logic [FETCH_W-1:0][31:0]      fetch_instr,
  input  logic [FETCH_W-1:0][31:0]      fetch_pc,
  output logic                          fetch_ready,
  input  logic                          flush,
  input  logic                          decode_ready,
  output logic [FETCH_W-1:0]            instr_valid,
  output logic [FETCH_W-1:0][31:0]      instr,
  output logic [FETCH_W-1:0][31:0]      pc,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] mem_instr_q [DEPTH];
  logic [31:0] mem_pc_q    [DEPTH];

  logic [CNT_W-1:0] lane_off [FETCH_W];
  logic [CNT_W-1:0] k_all;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] deq_n;
  logic             enq_en;

  // Space check uses only the registered occupancy.
  assign fetch_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W);
  assign enq_en      = fetch_ready && !flush;
  assign count       = count_q;

  // Compaction: each valid lane's slot offset is the number of valid lanes below it.
  always_comb begin
    k_all = '0;
    for (int i = 0; i < int'(FETCH_W); i++) begin
      lane_off[i] = k_all;
      if (fetch_valid[i]) k_all = k_all + CNT_W'(1);
    end
  end

  // Number of entries pushed and popped this cycle.
  always_comb begin
    enq_n = '0;
    deq_n = '0;
    if (enq_en) enq_n = k_all;
    if (decode_ready && !flush) begin
      deq_n = (count_q < CNT_W'(FETCH_W)) ? count_q : CNT_W'(FETCH_W);
    end
  end

  // Pointer and occupancy next state; flush overrides everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - deq_n;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage; contents are don't-care until covered by count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(FETCH_W); i++) begin
      if (enq_en && fetch_valid[i]) begin
        mem_instr_q[tail_q + PTR_W'(lane_off[i])] <= fetch_instr[i];
        mem_pc_q[tail_q + PTR_W'(lane_off[i])]    <= fetch_pc[i];
      end
    end
  end

  // Decode lanes: lane i shows entry head+i when occupied, zero otherwise.
  always_comb begin
    for (int i = 0; i < int'(FETCH_W); i++) begin
      instr_valid[i] = 1'b0;
      instr[i]       = '0;
      pc[i]          = '0;
      if (CNT_W'(i) < count_q) begin
        instr_valid[i] = 1'b1;
        instr[i]       = mem_instr_q[head_q + PTR_W'(i)];
        pc[i]          = mem_pc_q[head_q + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: table of per-cycle vectors with expected
// occupancy/valid/ready, plus a payload scoreboard and a mid-run reset sequence.
module tb_fetch_queue;

  logic             clk;
  logic             reset;
  logic [1:0]       fetch_valid;
  logic [1:0][31:0] fetch_instr;
  logic [1:0][31:0] fetch_pc;
  logic             fetch_ready;
  logic             flush;
  logic             decode_ready;
  logic [1:0]       instr_valid;
  logic [1:0][31:0] instr;
  logic [1:0][31:0] pc;
  logic [3:0]       count;

  fetch_queue #(.FETCH_W(2), .DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .flush(flush), .decode_ready(decode_ready),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fv;
    logic [31:0] pc0, pc1, in0, in1;
    logic        dr, fl;
    logic [3:0]  ecnt;
    logic [1:0]  evld;
    logic        erdy;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [31:0] ins_of(logic [31:0] p);
    return {p[15:0], 16'h0013};
  endfunction

  function automatic vec_t mk(logic [1:0] fv, logic [31:0] p0, logic [31:0] p1,
                              logic dr, logic fl, logic [3:0] ecnt,
                              logic [1:0] evld, logic erdy);
    vec_t v;
    v.fv = fv; v.pc0 = p0; v.pc1 = p1; v.in0 = ins_of(p0); v.in1 = ins_of(p1);
    v.dr = dr; v.fl = fl; v.ecnt = ecnt; v.evld = evld; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare decode lanes against the head of the scoreboard.
  task automatic sb_check(string tag);
    chk({tag, " sb_count"}, 32'(count), 32'(sb.size()));
    for (int i = 0; i < 2; i++) begin
      if (i < sb.size()) begin
        chk($sformatf("%s lane%0d pc", tag, i), pc[i], sb[i].pc);
        chk($sformatf("%s lane%0d instr", tag, i), instr[i], sb[i].ins);
      end else begin
        chk($sformatf("%s lane%0d pc_zero", tag, i), pc[i], 32'h0);
        chk($sformatf("%s lane%0d instr_zero", tag, i), instr[i], 32'h0);
      end
    end
  endtask

  // Drive one vector for one cycle, update the scoreboard, check after the edge.
  task automatic apply(int idx, vec_t v);
    bit          mrdy;
    logic [31:0] lp [2];
    logic [31:0] li [2];
    lp[0] = v.pc0; lp[1] = v.pc1; li[0] = v.in0; li[1] = v.in1;
    fetch_valid  = v.fv;
    fetch_pc     = {v.pc1, v.pc0};
    fetch_instr  = {v.in1, v.in0};
    decode_ready = v.dr;
    flush        = v.fl;
    mrdy = (8 - sb.size()) >= 2;
    @(posedge clk);
    if (v.fl) begin
      sb.delete();
    end else begin
      if (v.dr) begin
        for (int i = 0; i < 2; i++) if (sb.size() > 0) void'(sb.pop_front());
      end
      if (mrdy) begin
        for (int i = 0; i < 2; i++) if (v.fv[i]) sb.push_back('{lp[i], li[i]});
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d count", idx), 32'(count), 32'(v.ecnt));
    chk($sformatf("v%0d instr_valid", idx), 32'(instr_valid), 32'(v.evld));
    chk($sformatf("v%0d fetch_ready", idx), 32'(fetch_ready), 32'(v.erdy));
    sb_check($sformatf("v%0d", idx));
  endtask

  initial begin
    vec_t v;
    clk = 1'b0;
    reset = 1'b1;
    fetch_valid = '0; fetch_instr = '0; fetch_pc = '0;
    flush = 1'b0; decode_ready = 1'b0;

    // Basic enqueue then full-group dequeue (ADD / ADDI).
    v = mk(2'b11, 32'h1000, 32'h1004, 1'b0, 1'b0, 4'd2, 2'b11, 1'b1);
    v.in0 = 32'h003100B3; v.in1 = 32'h00108093;
    vecs.push_back(v);
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b1));
    // Gap compaction: only lane 1 valid.
    vecs.push_back(mk(2'b10, 32'hDEAD0000, 32'h1014, 1'b0, 1'b0, 4'd1, 2'b01, 1'b1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b1));
    // Streaming with constant occupancy across pointer wrap.
    vecs.push_back(mk(2'b11, 32'h1000, 32'h1004, 1'b0, 1'b0, 4'd2, 2'b11, 1'b1));
    for (int g = 1; g < 10; g++)
      vecs.push_back(mk(2'b11, 32'h1000 + 32'(8*g), 32'h1004 + 32'(8*g),
                        1'b1, 1'b0, 4'd2, 2'b11, 1'b1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b1));
    // Fill to full; fifth group ignored.
    vecs.push_back(mk(2'b11, 32'h2000, 32'h2004, 1'b0, 1'b0, 4'd2, 2'b11, 1'b1));
    vecs.push_back(mk(2'b11, 32'h2008, 32'h200C, 1'b0, 1'b0, 4'd4, 2'b11, 1'b1));
    vecs.push_back(mk(2'b11, 32'h2010, 32'h2014, 1'b0, 1'b0, 4'd6, 2'b11, 1'b1));
    vecs.push_back(mk(2'b11, 32'h2018, 32'h201C, 1'b0, 1'b0, 4'd8, 2'b11, 1'b0));
    vecs.push_back(mk(2'b11, 32'h2020, 32'h2024, 1'b0, 1'b0, 4'd8, 2'b11, 1'b0));
    // Count 7: enqueue refused while dequeue proceeds.
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'd6, 2'b11, 1'b1));
    vecs.push_back(mk(2'b01, 32'h2028, 32'h0, 1'b0, 1'b0, 4'd7, 2'b11, 1'b0));
    vecs.push_back(mk(2'b11, 32'h2030, 32'h2034, 1'b1, 1'b0, 4'd5, 2'b11, 1'b1));
    // Flush at count 6 beats both enqueue and dequeue.
    vecs.push_back(mk(2'b01, 32'h2038, 32'h0, 1'b0, 1'b0, 4'd6, 2'b11, 1'b1));
    vecs.push_back(mk(2'b11, 32'h3000, 32'h3004, 1'b1, 1'b1, 4'd0, 2'b00, 1'b1));
    vecs.push_back(mk(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 4'd0, 2'b00, 1'b1));

    // Reset state, checked before any clock edge.
    #2;
    chk("reset count", 32'(count), 32'd0);
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset fetch_ready", 32'(fetch_ready), 32'd1);
    chk("reset pc0", pc[0], 32'h0);
    chk("reset instr1", instr[1], 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Mid-operation asynchronous reset, then immediate acceptance afterwards.
    apply(100, mk(2'b11, 32'h4000, 32'h4004, 1'b0, 1'b0, 4'd2, 2'b11, 1'b1));
    fetch_valid = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset count", 32'(count), 32'd0);
    chk("midreset instr_valid", 32'(instr_valid), 32'd0);
    chk("midreset fetch_ready", 32'(fetch_ready), 32'd1);
    chk("midreset pc0", pc[0], 32'h0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    apply(101, mk(2'b11, 32'h5000, 32'h5004, 1'b0, 1'b0, 4'd2, 2'b11, 1'b1));
    apply(102, mk(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 2'b00, 1'b1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
